// File: rtl/rr_pkg.sv
// rr_pkg: shared state type and index-wrap helper for the round-robin burst scheduler
package rr_pkg;
  typedef enum logic {IDLE, OWN} rr_state_t;
  function automatic int wrap_inc(input int idx, input int n);
    return idx == n - 1 ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_burst_sched_if.sv
// rr_burst_sched_if: requester-bank / shared-resource handshake seen by the scheduler
interface rr_burst_sched_if #(
  parameter int REQCNT   = 5,
  parameter int REQWIDTH = $clog2(REQCNT),
  parameter int MAXBEATS = 8,
  parameter int BEATW    = $clog2(MAXBEATS)
);
  logic [REQCNT-1:0]   req_i;
  logic [REQCNT-1:0]   last_i;
  logic                beat_i;
  logic [REQCNT-1:0]   gnt_o;
  logic [REQWIDTH-1:0] gnt_num_o;
  logic                gnt_val_o;
  logic [BEATW-1:0]    beat_cnt_o;
  logic                rel_o;
  modport master (output req_i, last_i, beat_i, input gnt_o, gnt_num_o, gnt_val_o, beat_cnt_o, rel_o);
  modport slave  (input req_i, last_i, beat_i, output gnt_o, gnt_num_o, gnt_val_o, beat_cnt_o, rel_o);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority search returning the first request at or after ptr, with wrap
module rr_pick #(
  parameter int REQCNT   = 5,
  parameter int REQWIDTH = $clog2(REQCNT)
) (
  input  logic [REQCNT-1:0]   req,
  input  logic [REQWIDTH-1:0] ptr,
  output logic [REQWIDTH-1:0] winner,
  output logic                any
);
  function automatic int rot(input int p, input int i);
    return p + i >= REQCNT ? p + i - REQCNT : p + i;
  endfunction
  // scanned from the far end so the nearest set bit after ptr is written last
  always_comb begin
    winner = '0;
    any = |req;
    for (int i = REQCNT - 1; i >= 0; i--)
      if (req[REQWIDTH'(rot(int'(ptr), i))]) winner = REQWIDTH'(rot(int'(ptr), i));
  end
endmodule

// File: rtl/rr_burst_sched.sv
// rr_burst_sched: round-robin grant of a shared resource for multi-beat tenures
module rr_burst_sched import rr_pkg::*; #(
  parameter int REQCNT   = 5,
  parameter int REQWIDTH = $clog2(REQCNT),
  parameter int MAXBEATS = 8,
  parameter int BEATW    = $clog2(MAXBEATS)
) (
  input logic clk_i,
  input logic rst_i,
  rr_burst_sched_if.slave bus
);
  rr_state_t state, state_n;
  logic [REQWIDTH-1:0] ptr, ptr_n, num, num_n, win;
  logic [REQCNT-1:0] gnt, gnt_n;
  logic [BEATW-1:0] cnt, cnt_n;
  logic val, val_n, rel, rel_n, any, start, done;
  rr_pick #(.REQCNT(REQCNT), .REQWIDTH(REQWIDTH)) u_pick (
    .req(bus.req_i), .ptr(ptr), .winner(win), .any(any)
  );
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      ptr <= '0;
      num <= '0;
      gnt <= '0;
      cnt <= '0;
      val <= 1'b0;
      rel <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      num <= num_n;
      gnt <= gnt_n;
      cnt <= cnt_n;
      val <= val_n;
      rel <= rel_n;
    end
  // a beat coinciding with abandon still ends the tenure; it is simply not counted further
  always_comb begin
    start = state == IDLE && any;
    done = state == OWN && ((bus.beat_i && (bus.last_i[num] || cnt == BEATW'(MAXBEATS - 1))) || !bus.req_i[num]);
    state_n = state == IDLE ? (any ? OWN : IDLE) : (done ? IDLE : OWN);
  end
  always_comb begin
    gnt_n = start ? REQCNT'(1) << win : (done ? '0 : gnt);
    num_n = start ? win : num;
    cnt_n = start || done ? '0 : (state == OWN && bus.beat_i ? cnt + BEATW'(1) : cnt);
    val_n = start || (val && !done);
    rel_n = done;
    ptr_n = done ? REQWIDTH'(wrap_inc(int'(num), REQCNT)) : ptr;
  end
  assign bus.gnt_o = gnt;
  assign bus.gnt_num_o = num;
  assign bus.gnt_val_o = val;
  assign bus.beat_cnt_o = cnt;
  assign bus.rel_o = rel;
endmodule

// File: tb/tb_rr_burst_sched.sv
// tb_rr_burst_sched: scoreboarded bench for rr_burst_sched with REQCNT=5, MAXBEATS=4
module tb_rr_burst_sched;
  localparam int REQCNT = 5;
  localparam int MAXBEATS = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int seen_q[$];
  bit m_own = 1'b0;
  bit m_rel = 1'b0;
  int m_ptr = 0;
  int m_owner = 0;
  int m_cnt = 0;
  logic prev_val = 1'b0;
  rr_burst_sched_if #(.REQCNT(REQCNT), .MAXBEATS(MAXBEATS)) bus ();
  rr_burst_sched #(.REQCNT(REQCNT), .MAXBEATS(MAXBEATS)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // reference model: grant decisions are pushed as they are made from the driven inputs
  always @(posedge clk) begin
    automatic int w = -1;
    if (rst) begin
      m_own <= 1'b0;
      m_rel <= 1'b0;
      m_ptr <= 0;
      m_owner <= 0;
      m_cnt <= 0;
    end else begin
      m_rel <= 1'b0;
      if (!m_own) begin
        for (int k = 0; k < REQCNT; k++)
          if (w < 0 && bus.req_i[(m_ptr + k) % REQCNT]) w = (m_ptr + k) % REQCNT;
        if (w >= 0) begin
          m_own <= 1'b1;
          m_owner <= w;
          m_cnt <= 0;
          exp_q.push_back(w);
        end
      end else if ((bus.beat_i && (bus.last_i[m_owner] || m_cnt == MAXBEATS - 1)) || !bus.req_i[m_owner]) begin
        m_own <= 1'b0;
        m_cnt <= 0;
        m_rel <= 1'b1;
        m_ptr <= (m_owner + 1) % REQCNT;
      end else if (bus.beat_i) m_cnt <= m_cnt + 1;
    end
  end
  always @(negedge clk) begin
    chk("gnt", bus.gnt_o, m_own ? 32'(1 << m_owner) : 0);
    chk("gnt_val", bus.gnt_val_o, m_own);
    chk("beat_cnt", bus.beat_cnt_o, m_cnt);
    chk("rel", bus.rel_o, m_rel);
    if (bus.gnt_val_o && !prev_val) begin
      seen_q.push_back(int'(bus.gnt_num_o));
      if (exp_q.size() == 0) chk("sb_unexpected_grant", 1, 0);
      else chk("sb_grant", bus.gnt_num_o, exp_q.pop_front());
    end
    prev_val <= bus.gnt_val_o;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [4:0] req, input logic [4:0] last, input logic beat);
    bus.req_i = req;
    bus.last_i = last;
    bus.beat_i = beat;
  endtask
  task automatic wait_gnt(input string tag);
    for (int i = 0; i < 20 && !bus.gnt_val_o; i++) step();
    chk(tag, bus.gnt_val_o, 1);
  endtask
  task automatic chk_seq(input string tag, input int exp[$]);
    chk({tag, "_len"}, seen_q.size() >= exp.size(), 1);
    for (int i = 0; i < exp.size() && i < seen_q.size(); i++) chk(tag, seen_q[i], exp[i]);
  endtask
  initial begin
    drive(5'b11111, 5'b00000, 1'b0);
    step();
    step();
    chk("rst_gnt", bus.gnt_o, 0);
    chk("rst_val", bus.gnt_val_o, 0);
    chk("rst_num", bus.gnt_num_o, 0);
    chk("rst_rel", bus.rel_o, 0);
    seen_q.delete();
    rst = 1'b0;
    drive(5'b11111, 5'b00000, 1'b1);
    repeat (30) step();
    chk_seq("full_order", '{0, 1, 2, 3, 4, 0});
    drive(5'b00000, 5'b00000, 1'b0);
    repeat (3) step();
    drive(5'b00100, 5'b00000, 1'b1);
    wait_gnt("single_wait");
    chk("single_num", bus.gnt_num_o, 2);
    step();
    step();
    drive(5'b00100, 5'b00100, 1'b1);
    chk("single_held", bus.gnt_o, 5'b00100);
    step();
    chk("single_end_gnt", bus.gnt_o, 0);
    chk("single_end_rel", bus.rel_o, 1);
    drive(5'b01000, 5'b01000, 1'b1);
    wait_gnt("serve3_wait");
    chk("serve3_num", bus.gnt_num_o, 3);
    drive(5'b00000, 5'b00000, 1'b0);
    repeat (2) step();
    seen_q.delete();
    drive(5'b01001, 5'b01001, 1'b1);
    repeat (6) step();
    chk_seq("wrap_order", '{0, 3});
    drive(5'b00000, 5'b00000, 1'b0);
    repeat (2) step();
    drive(5'b00010, 5'b00000, 1'b0);
    wait_gnt("abandon_wait");
    chk("abandon_num", bus.gnt_num_o, 1);
    bus.beat_i = 1'b1;
    step();
    bus.beat_i = 1'b0;
    step();
    chk("abandon_cnt", bus.beat_cnt_o, 1);
    bus.req_i = 5'b00000;
    step();
    chk("abandon_gnt", bus.gnt_o, 0);
    chk("abandon_rel", bus.rel_o, 1);
    drive(5'b01010, 5'b00000, 1'b1);
    wait_gnt("ptr2_wait");
    chk("ptr2_num", bus.gnt_num_o, 3);
    step();
    rst = 1'b1;
    #3 rst = 1'b0;
    step();
    chk("glitch_cnt", bus.beat_cnt_o, 2);
    chk("glitch_val", bus.gnt_val_o, 1);
    rst = 1'b1;
    step();
    chk("midrst_gnt", bus.gnt_o, 0);
    chk("midrst_rel", bus.rel_o, 0);
    chk("midrst_cnt", bus.beat_cnt_o, 0);
    rst = 1'b0;
    drive(5'b11111, 5'b00000, 1'b0);
    wait_gnt("postrst_wait");
    chk("postrst_num", bus.gnt_num_o, 0);
    drive(5'b00000, 5'b00000, 1'b0);
    repeat (6) step();
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
